load_store_unit: RTL and testbench

- Multi-cycle load/store controller between the Mini-MIPS execute stage and the word-organised data memory.
- Accepts one byte, halfword or word request at a time over a valid/ready handshake.
- Performs little-endian lane extraction with sign or zero extension on loads.
- Turns sub-word stores into read-modify-write sequences, because the memory writes whole words only.
- Rejects misaligned and out-of-range accesses without touching memory.

---
 rtl/load_store_unit.sv | 154 +++++++++++++++
 tb/tb_load_store_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one byte/half/word access at a time to word-wide memory.
// Sub-word stores become read-modify-write; bad requests never reach memory.
module load_store_unit #(
    parameter int MEM_BYTES = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE, CHECK, LOAD, STORE, RMW_RD, RMW_WR, RESP
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        write_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic        bad_c;
    logic [7:0]  byte_c;
    logic [15:0] half_c;
    logic [31:0] lane_c;
    logic [31:0] merged_c;

    // Request legality: reserved size, misalignment or beyond memory.
    always_comb begin
        bad_c = (size_q == 2'b11)
              | ((size_q == 2'b01) & addr_q[0])
              | ((size_q == 2'b10) & (addr_q[1:0] != 2'b00))
              | (addr_q >= 32'(MEM_BYTES));
    end

    // Little-endian lane pick from the read word, then extension.
    always_comb begin
        byte_c = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_c = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (size_q)
            2'b00:   lane_c = {{24{signed_q & byte_c[7]}}, byte_c};
            2'b01:   lane_c = {{16{signed_q & half_c[15]}}, half_c};
            default: lane_c = mem_rdata;
        endcase
    end

    // Old word with only the target lane overwritten.
    always_comb begin
        merged_c = merge_q;
        if (size_q == 2'b00)
            merged_c[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged_c[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    // Next-state and memory-side outputs, decoded from state only.
    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_wdata  = '0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = CHECK;
            end
            CHECK: begin
                if (bad_c)                 state_nx = RESP;
                else if (!write_q)         state_nx = LOAD;
                else if (size_q == 2'b10)  state_nx = STORE;
                else                       state_nx = RMW_RD;
            end
            LOAD: begin
                mem_read = 1'b1;
                state_nx = RESP;
            end
            STORE: begin
                mem_write = 1'b1;
                mem_wdata = wdata_q;
                state_nx  = RESP;
            end
            RMW_RD: begin
                mem_read = 1'b1;
                state_nx = RMW_WR;
            end
            RMW_WR: begin
                mem_write = 1'b1;
                mem_wdata = merged_c;
                state_nx  = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign resp_err   = err_q;
    assign resp_rdata = rdata_q;

    // State, latched request fields and held response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                write_q  <= req_write;
                signed_q <= req_signed;
                size_q   <= req_size;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (state == RMW_RD)
                merge_q <= mem_rdata;
            if (state_nx == RESP) begin
                err_q   <= (state == CHECK);
                rdata_q <= (state == LOAD) ? lane_c : '0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table, random traffic against a
// byte-level memory model, plus hold-off and reset-abort sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] mem [512] = '{default: 32'h0};
    logic [31:0] ref_mem [512] = '{default: 32'h0};

    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_rd = '0;
    logic [31:0] last_wr = '0;

    load_store_unit #(.MEM_BYTES(2048)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[10:2]];

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[10:2]] <= mem_wdata;
            wr_cnt  <= wr_cnt + 1;
            last_wr <= mem_addr;
        end
        if (mem_read) begin
            rd_cnt  <= rd_cnt + 1;
            last_rd <= mem_addr;
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic int mem_diffs();
        int d = 0;
        for (int i = 0; i < 512; i++)
            if (mem[i] !== ref_mem[i]) d++;
        return d;
    endfunction

    function automatic logic [7:0] get_byte(logic [31:0] a);
        logic [31:0] w = ref_mem[a / 4];
        return 8'((w >> (8 * (a % 4))) & 32'hFF);
    endfunction

    function automatic void put_byte(logic [31:0] a, logic [7:0] b);
        int sh = 8 * int'(a % 4);
        ref_mem[a / 4] = (ref_mem[a / 4] & ~(32'hFF << sh))
                       | (32'(b) << sh);
    endfunction

    // Behavioural model: byte-addressed memory, n-byte accesses.
    task automatic model(input logic w, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a,
                         input logic [31:0] wd,
                         output logic err, output logic [31:0] rd,
                         output int lat, output int nrd,
                         output int nwr);
        int     n;
        longint v;
        n   = 1 << sz;
        err = (sz == 2'b11) || (a % n != 0) || (a >= 2048);
        rd  = '0;
        lat = 2;
        nrd = 0;
        nwr = 0;
        if (err) return;
        if (!w) begin
            v = 0;
            for (int i = 0; i < n; i++)
                v = v + (longint'(get_byte(a + i)) << (8 * i));
            if (sg && n < 4 && v[8 * n - 1])
                v = v - (longint'(1) << (8 * n));
            rd  = v[31:0];
            lat = 3;
            nrd = 1;
        end else begin
            for (int i = 0; i < n; i++)
                put_byte(a + i, 8'(wd >> (8 * i)));
            lat = (n == 4) ? 3 : 4;
            nrd = (n == 4) ? 0 : 1;
            nwr = 1;
        end
    endtask

    // Present a request, wait (bounded) for acceptance, then drop it.
    task automatic start(input logic w, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a,
                         input logic [31:0] wd);
        int t = 0;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) chk("accept_wait", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a,
                          input logic [31:0] wd, input logic e_err,
                          input logic [31:0] e_rd, input int e_lat,
                          input int e_nrd, input int e_nwr,
                          input string nm);
        int r0;
        int w0;
        int lat;
        r0 = rd_cnt;
        w0 = wr_cnt;
        start(w, sz, sg, a, wd);
        lat = 1;
        while (!resp_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, ".lat"}, 32'(lat), 32'(e_lat));
        chk({nm, ".err"}, 32'(resp_err), 32'(e_err));
        chk({nm, ".rdata"}, resp_rdata, e_rd);
        chk({nm, ".nrd"}, 32'(rd_cnt - r0), 32'(e_nrd));
        chk({nm, ".nwr"}, 32'(wr_cnt - w0), 32'(e_nwr));
        if (e_nrd > 0)
            chk({nm, ".rdaddr"}, last_rd, {a[31:2], 2'b00});
        if (e_nwr > 0)
            chk({nm, ".wraddr"}, last_wr, {a[31:2], 2'b00});
        chk({nm, ".memimg"}, 32'(mem_diffs()), 32'd0);
        @(negedge clk);
        chk({nm, ".ready"}, 32'(req_ready), 32'd1);
    endtask

    // Reset during the cycle after CHECK; stores still commit.
    task automatic abort(input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         input string nm);
        logic        e;
        logic [31:0] r;
        int          l, nr, nw;
        logic        quiet;
        start(w, sz, 1'b0, a, wd);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk({nm, ".ready"}, 32'(req_ready), 32'd1);
        chk({nm, ".resp"}, 32'(resp_valid), 32'd0);
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) quiet = 1'b0;
        end
        chk({nm, ".quiet"}, 32'(quiet), 32'd1);
        if (w && sz == 2'b10) model(w, sz, 1'b0, a, wd, e, r, l, nr, nw);
        chk({nm, ".memimg"}, 32'(mem_diffs()), 32'd0);
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic        e;
        logic [31:0] r;
        int          l, nr, nw, k;
        logic        busy_ok;
        logic [1:0]  sz;
        logic [31:0] a;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (3) @(negedge clk);
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_err", 32'(resp_err), 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'd0);
        chk("rst.mem_read", 32'(mem_read), 32'd0);
        chk("rst.mem_write", 32'(mem_write), 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        tbl.push_back('{1, 2, 0, 32'h01C, 32'h3F78F5C3, 0, 0, 3});
        tbl.push_back('{0, 2, 0, 32'h01C, 0, 0, 32'h3F78F5C3, 3});
        tbl.push_back('{1, 2, 0, 32'h020, 32'h80FF7F01, 0, 0, 3});
        tbl.push_back('{0, 0, 1, 32'h021, 0, 0, 32'h0000007F, 3});
        tbl.push_back('{0, 0, 1, 32'h023, 0, 0, 32'hFFFFFF80, 3});
        tbl.push_back('{0, 0, 0, 32'h022, 0, 0, 32'h000000FF, 3});
        tbl.push_back('{0, 1, 1, 32'h022, 0, 0, 32'hFFFF80FF, 3});
        tbl.push_back('{0, 1, 0, 32'h020, 0, 0, 32'h00007F01, 3});
        tbl.push_back('{1, 2, 0, 32'h020, 32'h11223344, 0, 0, 3});
        tbl.push_back('{1, 0, 0, 32'h022, 32'h000000AB, 0, 0, 4});
        tbl.push_back('{0, 2, 0, 32'h020, 0, 0, 32'h11AB3344, 3});
        tbl.push_back('{1, 1, 0, 32'h020, 32'h1234BEEF, 0, 0, 4});
        tbl.push_back('{0, 2, 0, 32'h020, 0, 0, 32'h11ABBEEF, 3});
        tbl.push_back('{0, 2, 0, 32'h01C, 0, 0, 32'h3F78F5C3, 3});
        tbl.push_back('{0, 2, 0, 32'h002, 0, 1, 0, 2});
        tbl.push_back('{0, 1, 0, 32'h001, 0, 1, 0, 2});
        tbl.push_back('{0, 3, 0, 32'h010, 0, 1, 0, 2});
        tbl.push_back('{0, 2, 0, 32'h800, 0, 1, 0, 2});
        tbl.push_back('{1, 0, 0, 32'h800, 32'h55, 1, 0, 2});
        tbl.push_back('{1, 2, 0, 32'h021, 32'h99, 1, 0, 2});
        tbl.push_back('{1, 2, 0, 32'h7FC, 32'hCAFEF00D, 0, 0, 3});
        tbl.push_back('{0, 2, 0, 32'h7FC, 0, 0, 32'hCAFEF00D, 3});
        tbl.push_back('{0, 0, 1, 32'h7FF, 0, 0, 32'hFFFFFFCA, 3});

        foreach (tbl[i]) begin
            model(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd,
                  e, r, l, nr, nw);
            do_req(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd,
                   tbl[i].err, tbl[i].rd, tbl[i].lat, nr, nw,
                   $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 250; i++) begin
            logic        w;
            logic        sg;
            logic [31:0] wd;
            w  = 1'($urandom);
            sg = 1'($urandom);
            wd = $urandom;
            sz = 2'($urandom);
            if ($urandom_range(0, 9) == 0)
                a = $urandom_range(2040, 2200);
            else
                a = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) a = a & ~32'(3 >> (2 - sz % 3));
            model(w, sz, sg, a, wd, e, r, l, nr, nw);
            do_req(w, sz, sg, a, wd, e, r, l, nr, nw,
                   $sformatf("rnd%0d", i));
        end

        // Second request held while an RMW is in progress.
        model(1, 0, 0, 32'h031, 32'h5A, e, r, l, nr, nw);
        req_write  = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h031;
        req_wdata  = 32'h5A;
        req_valid  = 1'b1;
        chk("hold.first_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_write = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h030;
        req_wdata = 32'h0;
        busy_ok   = 1'b1;
        k = 1;
        while (!resp_valid && k < 12) begin
            if (req_ready) busy_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        chk("hold.lat", 32'(k), 32'd4);
        chk("hold.busy_ready", 32'(busy_ok), 32'd1);
        chk("hold.resp_ready", 32'(req_ready), 32'd0);
        chk("hold.err", 32'(resp_err), 32'd0);
        chk("hold.rdata", resp_rdata, 32'd0);
        @(negedge clk);
        chk("hold.idle_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("hold.accepted", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        model(0, 2, 0, 32'h030, 0, e, r, l, nr, nw);
        k = 1;
        while (!resp_valid && k < 12) begin
            @(negedge clk);
            k++;
        end
        chk("hold.lat2", 32'(k), 32'd3);
        chk("hold.rdata2", resp_rdata, r);
        chk("hold.memimg", 32'(mem_diffs()), 32'd0);
        @(negedge clk);

        abort(0, 2'b10, 32'h040, 32'h0, "rst_load");
        abort(1, 2'b00, 32'h045, ~ref_mem[17], "rst_rmw");
        abort(1, 2'b10, 32'h048, ~ref_mem[18], "rst_store");
        model(0, 2, 0, 32'h048, 0, e, r, l, nr, nw);
        do_req(0, 2, 0, 32'h048, 0, e, r, l, nr, nw, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
